echo_timer: RTL
===============

// Module: echo_timer
// PURPOSE
//  Round-trip timing stage directly downstream of the edge detector on the delay line.
//  Issues a one-cycle transmit pulse into the line, then counts clk cycles until the edge
//  detector's one-cycle output pulse returns. Averages 2**AVG_LOG2 round trips and
//  reports the mean delay, or a timeout error when no echo arrives.
// PARAMETERS
//  CTR_WIDTH  16     width of the round-trip counter and of result
//  TIMEOUT    50000  cycles after tx_pulse with no echo before abort; must be < 2**CTR_WIDTH
//  BLANK      20     echoes at count <= BLANK are ignored (covers tx crosstalk and detector re-arm)
//  AVG_LOG2   2      log2 of the number of round trips averaged per result (0 = single shot)
// PORTS
//  clk          in   1          system clock; all logic is on its rising edge
//  rst          in   1          synchronous, active-high reset
//  start        in   1          request one measurement batch; sampled only in IDLE
//  edge_in      in   1          one-cycle echo pulse from the edge detector output
//  tx_pulse     out  1          one-cycle pulse that launches a transmission into the line
//  busy         out  1          high in every state except IDLE
//  result       out  CTR_WIDTH  mean round-trip cycles of the last completed batch
//  result_valid out  1          one-cycle strobe: result updated this cycle
//  timeout_err  out  1          one-cycle strobe: batch aborted, no echo within TIMEOUT
// BEHAVIOUR
//  Reset: state=IDLE; tx_pulse, busy, result_valid, timeout_err=0; result=0; cnt, acc, n=0.
//  States: IDLE, TX, LISTEN, DONE.
//   IDLE  : start=1 -> TX; acc<=0; n<=0. start is ignored in all other states (no queueing).
//   TX    : tx_pulse=1 for this cycle only; cnt<=1 -> LISTEN.
//   LISTEN: each cycle, if edge_in=1 and cnt>BLANK, the sample is cnt: acc<=acc+cnt, n<=n+1;
//           if n+1 == 2**AVG_LOG2 -> DONE, else -> TX. With no accepted edge, cnt<=cnt+1.
//           If cnt==TIMEOUT and no edge is accepted -> IDLE; timeout_err=1 in that
//           transition cycle; acc/n cleared; result is unchanged.
//   DONE  : result<=acc>>AVG_LOG2 (truncating); result_valid=1 -> IDLE.
//  Sample definition: the tx_pulse cycle is count 0. An echo sampled k cycles later gives
//   sample k, so the minimum reportable sample is BLANK+1.
//  Latency: start at cycle t -> tx_pulse at t+1. With an echo at cycle t+1+k on the final
//   trip: DONE at t+2+k, result/result_valid visible at t+3+k. Consecutive trips restart
//   with no gap: the next tx_pulse occurs one cycle after the accepted edge.
//  Widths: acc is CTR_WIDTH+AVG_LOG2 bits and cannot overflow; cnt never exceeds TIMEOUT.
//  Boundaries:
//   - edge at cnt==BLANK: ignored. edge at cnt==BLANK+1: accepted.
//   - edge and cnt==TIMEOUT in the same cycle: the edge wins and counts as a valid sample.
//   - edge_in during IDLE, TX or DONE: ignored.
//   - start held high continuously: a new batch begins on the cycle after DONE or timeout
//     returns to IDLE (i.e. IDLE is occupied for 1 cycle).
//   - rst mid-batch: the batch is abandoned; no result_valid or timeout_err strobe;
//     result returns to 0.
// STRUCTURE
//  delay_line_pkg: state enum (IDLE, TX, LISTEN, DONE) and the default CTR_WIDTH constant,
//   shared with the edge detector and top level.
//  One sub-module: echo_accum (clear, add-sample, mean output; acc and n registers).
//   The FSM and cnt stay in echo_timer.
// TESTING
//  1 Defaults; start at t=0; edge_in pulsed 100 cycles after each tx_pulse, 4 trips
//    -> 4 tx_pulses, each 101 cycles apart; result=100, result_valid once, busy low after.
//  2 AVG_LOG2=2; echoes at 100, 101, 102, 104 -> result=101 (407>>2, truncated).
//  3 Echo at k=20 then k=21, with AVG_LOG2=0 -> the k=20 echo is ignored; result=21.
//  4 No echo; TIMEOUT=50 -> timeout_err exactly 50 cycles after tx_pulse;
//    result keeps its previous value; busy=0 on the following cycle.
//  5 Edge coincident with cnt==TIMEOUT (TIMEOUT=50, AVG_LOG2=0) -> result=50, no timeout_err.
//  6 rst asserted mid-LISTEN of trip 2; start pulsed while busy
//    -> no strobes; all outputs 0 after rst; the busy-time start is ignored.

Source files
------------

// File: rtl/delay_line_pkg.sv
// Types and defaults shared by the delay-line stages (edge detector, echo timer, top level).
package delay_line_pkg;

  localparam int unsigned CTR_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TX     = 2'd1,
    LISTEN = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/echo_accum.sv
// Round-trip sample accumulator: sums 2**AVG_LOG2 samples and presents their truncated mean.
module echo_accum
  import delay_line_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = CTR_WIDTH_DEFAULT,
  parameter int unsigned AVG_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 add,
  input  logic [CTR_WIDTH-1:0] sample,
  output logic                 last,
  output logic [CTR_WIDTH-1:0] mean
);

  localparam int unsigned ACC_W = CTR_WIDTH + AVG_LOG2;
  localparam int unsigned N_W   = AVG_LOG2 + 1;

  logic [ACC_W-1:0] acc;
  logic [N_W-1:0]   n;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
      n   <= '0;
    end else if (add) begin
      acc <= acc + ACC_W'(sample);
      n   <= n + N_W'(1);
    end
  end

  // The sample being added now completes the batch when n is one short of the full count.
  assign last = (n == N_W'((1 << AVG_LOG2) - 1));
  assign mean = CTR_WIDTH'(acc >> AVG_LOG2);

endmodule

// File: rtl/echo_timer.sv
// Round-trip timer: pulses the delay line, counts cycles to the returning echo, averages the trips.
module echo_timer
  import delay_line_pkg::*;
#(
  parameter int unsigned CTR_WIDTH = CTR_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned BLANK     = 20,
  parameter int unsigned AVG_LOG2  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 edge_in,
  output logic                 tx_pulse,
  output logic                 busy,
  output logic [CTR_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic                 timeout_err
);

  state_t               state, state_nxt;
  logic [CTR_WIDTH-1:0] cnt;
  logic [CTR_WIDTH-1:0] mean;
  logic                 accept;
  logic                 last;
  logic                 at_timeout;
  logic                 clear;

  // Echoes inside the blanking window are transmit crosstalk or detector re-arm noise.
  assign accept     = (state == LISTEN) && edge_in && (cnt > CTR_WIDTH'(BLANK));
  assign at_timeout = (cnt == CTR_WIDTH'(TIMEOUT));
  assign clear      = ((state == IDLE) && start) || timeout_err;

  echo_accum #(
    .CTR_WIDTH (CTR_WIDTH),
    .AVG_LOG2  (AVG_LOG2)
  ) u_accum (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .add    (accept),
    .sample (cnt),
    .last   (last),
    .mean   (mean)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = TX;
      TX:      state_nxt = LISTEN;
      LISTEN: begin
        if (accept)          state_nxt = last ? DONE : TX;
        else if (at_timeout) state_nxt = IDLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_pulse    = (state == TX);
    busy        = (state != IDLE);
    timeout_err = (state == LISTEN) && at_timeout && !accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= (state == DONE);
      if (state == DONE) result <= mean;
      if (state == TX) begin
        cnt <= CTR_WIDTH'(1);
      end else if ((state == LISTEN) && !accept) begin
        cnt <= at_timeout ? '0 : cnt + CTR_WIDTH'(1);
      end
    end
  end

endmodule
